// File: rtl/s6_stream_adapter_pkg.sv
// Shared defaults and helpers for the s6 stream adapter, its result FIFO and the s6 core.
package s6_stream_adapter_pkg;

    localparam int unsigned DATAWIDTH_DEF  = 64;
    localparam int unsigned TAG_W_DEF      = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned RES_CNT_W      = 16;

    // Result counter increment that sticks at all-ones.
    function automatic logic [RES_CNT_W-1:0] sat_inc(input logic [RES_CNT_W-1:0] v);
        return (v == '1) ? v : v + RES_CNT_W'(1);
    endfunction

endpackage

// File: rtl/s6.sv
// Registered s6 datapath: z = (a % c == zero) ? c+1 : a-1, signed, wrapping.
module s6
    import s6_stream_adapter_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] a_i,
    input  logic [DATAWIDTH-1:0] b_i,
    input  logic [DATAWIDTH-1:0] c_i,
    input  logic [DATAWIDTH-1:0] zero_i,
    output logic [DATAWIDTH-1:0] z_o
);

    logic [DATAWIDTH-1:0] rem_c;
    logic [DATAWIDTH-1:0] z_d;
    logic [DATAWIDTH-1:0] z_q;
    logic                 unused_b;

    assign unused_b = ^b_i;

    // c == 0 is flagged upstream; c == -1 always leaves remainder 0 and avoids min/-1 overflow.
    always_comb begin
        rem_c = '0;
        if ((c_i != '0) && (c_i != '1)) begin
            rem_c = DATAWIDTH'($signed(a_i) % $signed(c_i));
        end
        z_d = (rem_c == zero_i) ? (c_i + DATAWIDTH'(1)) : (a_i - DATAWIDTH'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q <= '0;
        end else begin
            z_q <= z_d;
        end
    end

    assign z_o = z_q;

endmodule

// File: rtl/s6_result_fifo.sv
// Show-ahead synchronous FIFO with async reset; head data reads as zero while empty.
module s6_result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_c;
    logic             pop_c;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign push_c = wr_en_i && !full_o;
    assign pop_c  = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_c);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Upstream credit accounting must never let a write land on a full FIFO.
    assert property (@(posedge clk) disable iff (rst) !(wr_en_i && full_o));

endmodule

// File: rtl/s6_stream_adapter.sv
// Valid/ready wrapper around the s6 core: operand staging, tag/div0 shadowing,
// credit-based upstream backpressure and a show-ahead result FIFO.
module s6_stream_adapter
    import s6_stream_adapter_pkg::*;
#(
    parameter int unsigned DATAWIDTH  = DATAWIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned TAG_W      = TAG_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_a,
    input  logic [DATAWIDTH-1:0] in_b,
    input  logic [DATAWIDTH-1:0] in_c,
    input  logic [DATAWIDTH-1:0] in_zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_z,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_div0,
    output logic [RES_CNT_W-1:0] res_count
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    typedef struct packed {
        logic                 div0;
        logic [TAG_W-1:0]     tag;
        logic [DATAWIDTH-1:0] z;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    logic [DATAWIDTH-1:0] op_a_q, op_a_d;
    logic [DATAWIDTH-1:0] op_b_q, op_b_d;
    logic [DATAWIDTH-1:0] op_c_q, op_c_d;
    logic [DATAWIDTH-1:0] op_zero_q, op_zero_d;
    logic [TAG_W-1:0]     op_tag_q, op_tag_d;
    logic                 op_div0_q, op_div0_d;
    logic                 v0_q, v0_d;
    logic                 v1_q, v1_d;
    logic [TAG_W-1:0]     s1_tag_q, s1_tag_d;
    logic                 s1_div0_q, s1_div0_d;
    logic [TAG_W-1:0]     tag_cnt_q, tag_cnt_d;
    logic [RES_CNT_W-1:0] res_count_q, res_count_d;

    logic [DATAWIDTH-1:0] core_z;
    entry_t               wr_entry_c;
    entry_t               rd_entry;
    logic [ENTRY_W-1:0]   rd_data;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W:0]       credit_used_c;
    logic                 accept_c;
    logic                 pop_c;

    // Every tuple in flight already owns a FIFO slot, so the write can never overflow.
    assign credit_used_c = {1'b0, fifo_count} + (CNT_W+1)'(v0_q) + (CNT_W+1)'(v1_q);
    assign in_ready      = !rst && !fifo_full && (credit_used_c < (CNT_W+1)'(FIFO_DEPTH));
    assign accept_c      = in_valid && in_ready;
    assign pop_c         = !fifo_empty && out_ready;

    always_comb begin
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_c_d      = op_c_q;
        op_zero_d   = op_zero_q;
        op_tag_d    = op_tag_q;
        op_div0_d   = op_div0_q;
        s1_tag_d    = s1_tag_q;
        s1_div0_d   = s1_div0_q;
        tag_cnt_d   = tag_cnt_q;
        res_count_d = res_count_q;
        v0_d        = accept_c;
        v1_d        = v0_q;

        if (accept_c) begin
            op_a_d    = in_a;
            op_b_d    = in_b;
            op_c_d    = in_c;
            op_zero_d = in_zero;
            op_tag_d  = tag_cnt_q;
            op_div0_d = (in_c == '0);
            tag_cnt_d = tag_cnt_q + TAG_W'(1);
        end

        // Shadow follows the core register so tag/div0 line up with core_z.
        if (v0_q) begin
            s1_tag_d  = op_tag_q;
            s1_div0_d = op_div0_q;
        end

        if (pop_c) begin
            res_count_d = sat_inc(res_count_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_c_q      <= '0;
            op_zero_q   <= '0;
            op_tag_q    <= '0;
            op_div0_q   <= 1'b0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            s1_tag_q    <= '0;
            s1_div0_q   <= 1'b0;
            tag_cnt_q   <= '0;
            res_count_q <= '0;
        end else begin
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_c_q      <= op_c_d;
            op_zero_q   <= op_zero_d;
            op_tag_q    <= op_tag_d;
            op_div0_q   <= op_div0_d;
            v0_q        <= v0_d;
            v1_q        <= v1_d;
            s1_tag_q    <= s1_tag_d;
            s1_div0_q   <= s1_div0_d;
            tag_cnt_q   <= tag_cnt_d;
            res_count_q <= res_count_d;
        end
    end

    s6 #(
        .DATAWIDTH (DATAWIDTH)
    ) u_s6 (
        .clk    (clk),
        .rst    (rst),
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .c_i    (op_c_q),
        .zero_i (op_zero_q),
        .z_o    (core_z)
    );

    always_comb begin
        wr_entry_c.div0 = s1_div0_q;
        wr_entry_c.tag  = s1_tag_q;
        wr_entry_c.z    = s1_div0_q ? '0 : core_z;
    end

    s6_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (v1_q),
        .wr_data_i (wr_entry_c),
        .rd_en_i   (out_ready),
        .rd_data_o (rd_data),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (fifo_count)
    );

    assign rd_entry  = entry_t'(rd_data);
    assign out_valid = !fifo_empty;
    assign out_z     = rd_entry.z;
    assign out_tag   = rd_entry.tag;
    assign out_div0  = rd_entry.div0;
    assign res_count = res_count_q;

endmodule

// File: tb/tb_s6_stream_adapter.sv
// Directed self-checking bench for s6_stream_adapter with an in-order expected-result queue.
module tb_s6_stream_adapter;

    localparam int unsigned DW = 64;
    localparam int unsigned TW = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [DW-1:0] in_c;
    logic [DW-1:0] in_zero;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_z;
    logic [TW-1:0] out_tag;
    logic          out_div0;
    logic [15:0]   res_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] z;
        logic [7:0]  tag;
        logic        div0;
    } exp_t;

    exp_t exp_q[$];
    int   exp_tag = 0;

    s6_stream_adapter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_tag   (out_tag),
        .out_div0  (out_div0),
        .res_count (res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] ez, input logic ediv);
        exp_t e;
        e.z    = ez;
        e.tag  = exp_tag[7:0];
        e.div0 = ediv;
        exp_q.push_back(e);
        exp_tag++;
    endtask

    // Present one tuple, hold until accepted, record its hand-computed result.
    task automatic send(input logic [63:0] a, input logic [63:0] c, input logic [63:0] zero,
                        input logic [63:0] ez, input logic ediv);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = {$urandom, $urandom};
        in_c     = c;
        in_zero  = zero;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("send_timeout", 64'(in_ready), 64'd1);
        else push_exp(ez, ediv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        check_eq("empty_after_drain", 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        #2;
        exp_q.delete();
        exp_tag = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard: every pop must match the oldest expected result.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_pop", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("pop_z", out_z, e.z);
                check_eq("pop_tag", 64'(out_tag), 64'(e.tag));
                check_eq("pop_div0", 64'(out_div0), 64'(e.div0));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int acc;
        int sent;
        int stalls;
        int cyc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        in_zero   = '0;

        // Reset state
        #12;
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_z", out_z, 64'd0);
        check_eq("rst_out_tag", 64'(out_tag), 64'd0);
        check_eq("rst_out_div0", 64'(out_div0), 64'd0);
        check_eq("rst_res_count", 64'(res_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

        // 1: single tuple, 10 % 3 == 1 -> c+1 = 4, out_valid three edges after presentation
        send(64'd10, 64'd3, 64'd1, 64'd4, 1'b0);
        @(negedge clk);
        check_eq("lat_edge_k", 64'(out_valid), 64'd0);
        @(negedge clk);
        check_eq("lat_edge_k1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check_eq("lat_edge_k2", 64'(out_valid), 64'd1);
        check_eq("t1_z", out_z, 64'd4);
        check_eq("t1_tag", 64'(out_tag), 64'd0);
        check_eq("t1_div0", 64'(out_div0), 64'd0);
        wait_drain();
        check_eq("t1_res_count", 64'(res_count), 64'd1);

        // 2: 7 % 3 = 1 != 0 -> 6; -7 % 3 = -1 == -1 -> 4
        do_reset();
        send(64'd7, 64'd3, 64'd0, 64'd6, 1'b0);
        send(64'(-7), 64'd3, 64'(-1), 64'd4, 1'b0);
        wait_drain();
        check_eq("t2_res_count", 64'(res_count), 64'd2);

        // 3: divide by zero forces z=0 and div0, next tuple 10 % 5 == 0 -> 6
        do_reset();
        send(64'd5, 64'd0, 64'd0, 64'd0, 1'b1);
        send(64'd10, 64'd5, 64'd0, 64'd6, 1'b0);
        wait_drain();

        // 4: backpressure, c=1 gives remainder 0 != 7 so z = a-1
        do_reset();
        out_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_a    = 64'(100 + acc);
            in_c    = 64'd1;
            in_zero = 64'd7;
            @(negedge clk);
            if (in_ready) begin
                push_exp(64'(99 + acc), 1'b0);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_eq("bp_accepted", 64'(acc), 64'd4);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
        check_eq("bp_hold_z", out_z, 64'd99);
        check_eq("bp_hold_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        check_eq("bp_hold_z2", out_z, 64'd99);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            #1;
            check_eq("bp_drain_rate", 64'(exp_q.size()), 64'(3 - j));
        end
        wait_drain();
        check_eq("bp_res_count", 64'(res_count), 64'd4);

        // 5: stream 300 tuples, z = a-1 = index, tags wrap past 255
        do_reset();
        out_ready = 1'b1;
        sent      = 0;
        stalls    = 0;
        cyc       = 0;
        in_valid  = 1'b1;
        while (sent < 300 && cyc < 1000) begin
            in_a    = 64'(sent + 1);
            in_b    = {$urandom, $urandom};
            in_c    = 64'd1;
            in_zero = 64'd5;
            @(negedge clk);
            if (in_ready) begin
                push_exp(64'(sent), 1'b0);
                sent++;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("stream_sent", 64'(sent), 64'd300);
        check_eq("stream_stalls", 64'(stalls), 64'd0);
        wait_drain();
        check_eq("stream_res_count", 64'(res_count), 64'd300);

        // 6: reset with two results queued and two in flight
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(64'(20 + i), 64'd1, 64'd9, 64'(19 + i), 1'b0);
        end
        check_eq("mid_valid", 64'(out_valid), 64'd1);
        check_eq("mid_z", out_z, 64'd19);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_valid", 64'(out_valid), 64'd0);
        check_eq("async_z", out_z, 64'd0);
        check_eq("async_tag", 64'(out_tag), 64'd0);
        check_eq("async_div0", 64'(out_div0), 64'd0);
        check_eq("async_in_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        exp_tag = 0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("flush_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        // 3 % 2 == 1 -> c+1 = 3, first tag after reset is 0
        send(64'd3, 64'd2, 64'd1, 64'd3, 1'b0);
        wait_drain();
        check_eq("flush_res_count", 64'(res_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
